prom_arbiter: RTL

PROM_ARBITER -- requirements
Module: prom_arbiter

---
 rtl/prom_arbiter_pkg.sv | 17 +
 rtl/prom_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/prom_arbiter_pkg.sv
// Shared definitions for the two-requester PROM read arbiter: width defaults,
// requester indices and the contention winner helper.
package prom_arbiter_pkg;

  localparam int ADR_W_DEF  = 9;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Winner when both requesters are valid: round-robin favours the requester
  // that did not win last time, fixed priority always picks the CPU.
  function automatic logic contention_winner(input logic rr_en, input logic last_grant);
    return rr_en ? ~last_grant : REQ_CPU;
  endfunction

endpackage

// File: rtl/prom_arbiter.sv
// Two-requester PROM read arbiter with a fixed 1-cycle response.
// Define PROM_ARB_RR_EN for round-robin on contention; default is fixed CPU priority.
module prom_arbiter
  import prom_arbiter_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADR_W-1:0]  req0_adr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADR_W-1:0]  req1_adr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              prom_ce,
  output logic [ADR_W-1:0]  prom_adr,
  input  logic [DATA_W-1:0] prom_data
);

  // Handshake: a request is accepted when reqN_valid && reqN_ready; the
  // requester holds valid/adr until then. Responses carry no ready and
  // appear exactly one cycle after acceptance.

`ifdef PROM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic last_grant;
  logic gnt0;
  logic gnt1;
  logic rsp0_q;
  logic rsp1_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (contention_winner(RR_EN, last_grant) == REQ_LDR) gnt1 = 1'b1;
        else                                                  gnt0 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign prom_ce    = gnt0 | gnt1;

  always_comb begin
    prom_adr = '0;
    if (gnt0)      prom_adr = req0_adr;
    else if (gnt1) prom_adr = req1_adr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_LDR;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      rsp0_q <= gnt0;
      rsp1_q <= gnt1;
      if (gnt0 || gnt1) last_grant <= gnt1;
    end
  end

  // Reset also kills a response still in flight from the cycle before it.
  assign rsp0_valid = rsp0_q & ~rst;
  assign rsp1_valid = rsp1_q & ~rst;
  assign rsp_data   = prom_data;

endmodule
